axis_chk: RTL and testbench

- AXI-Stream sink and checker. It is the receiving end for the LFSR stream source in fv_enc, intended for encoder datapath loopback and bring-up.
- It accepts beats, self-synchronises a reference 64-bit LFSR on a frame boundary, then checks every later beat's data and TLAST framing.
- It reports lock status and saturating error counters. Optional built-in backpressure exercises the source handshake.

---
 rtl/fv_enc_pkg.sv | 19 +
 rtl/axis_chk_if.sv | 12 +
 rtl/lfsr_64bit_en.sv | 25 ++
 rtl/axis_chk.sv | 128 ++++++++++++
 tb/tb_axis_chk.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fv_enc_pkg.sv
// Shared LFSR definitions for the fv_enc stream source and its loopback checker.
// The tap set and next-state function must stay bit-identical to lfsr_64bit.
package fv_enc_pkg;

  localparam int LFSR_W = 64;

  // Fibonacci feedback from bits 63, 62, 60, 59 (x^64 + x^63 + x^61 + x^60 + 1)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_chk_if.sv
// AXI-Stream beat bundle: in = sink side, out = source side.
interface axis_if #(
  parameter int DATAW = 64
);
  logic [DATAW-1:0] data;
  logic             vld;
  logic             last;
  logic             rdy;

  modport in  (input  data, input  vld, input  last, output rdy);
  modport out (output data, output vld, output last, input  rdy);
endinterface

// File: rtl/lfsr_64bit_en.sv
// Reference LFSR for the checker: same polynomial as lfsr_64bit, but seeded by
// a load port and advanced only on enable.
module lfsr_64bit_en
  import fv_enc_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] state_nxt
);

  assign state_nxt = lfsr_next(state);

  // Pure datapath register: it is always loaded before it is used, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      state <= load_val;
    end else if (en) begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/axis_chk.sv
// AXI-Stream LFSR sink: self-syncs on a TLAST beat, then checks data and
// framing of every accepted beat, with saturating error counters.
module axis_chk
  import fv_enc_pkg::*;
#(
  parameter int N         = 16,
  parameter int DATAW     = 64,
  parameter int BP_EN     = 0,
  parameter int BP_PERIOD = 7,
  parameter int LOSS_THR  = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  axis_if.in          lfsr_in,
  input  logic        clr,
  output logic        locked,
  output logic [31:0] frame_cnt,
  output logic [15:0] data_err_cnt,
  output logic [15:0] last_err_cnt,
  output logic        err_sticky
);

  localparam int BCW = (N > 1) ? $clog2(N) : 1;
  localparam int RCW = $clog2(LOSS_THR + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(N - 1);
  localparam logic [RCW-1:0] RUN_LIMIT = RCW'(LOSS_THR);
  localparam logic [7:0]     BP_TOP    = 8'(BP_PERIOD - 1);

  if (DATAW != LFSR_W) begin : g_bad_dataw
    $error("axis_chk: DATAW must be 64 so a beat can seed the full LFSR state");
  end

  chk_state_e        state;
  logic [BCW-1:0]    beat_cnt;
  logic [RCW-1:0]    run_cnt;
  logic [RCW-1:0]    run_inc;
  logic [7:0]        bp_cnt;
  logic [7:0]        bp_cnt_nxt;
  logic [LFSR_W-1:0] ref_state;
  logic [LFSR_W-1:0] ref_nxt;
  logic              accept;
  logic              in_lock;
  logic              beat_hit;
  logic              data_bad;
  logic              at_end;
  logic              last_bad;
  logic              lost;

  assign accept   = lfsr_in.vld && lfsr_in.rdy;
  assign in_lock  = (state == LOCK);
  assign beat_hit = accept && in_lock;
  assign data_bad = (lfsr_in.data != ref_nxt);
  assign at_end   = (beat_cnt == LAST_BEAT);
  assign last_bad = (lfsr_in.last != at_end);
  assign run_inc  = run_cnt + RCW'(1);
  assign lost     = data_bad && (run_inc == RUN_LIMIT);
  assign locked   = in_lock;

  lfsr_64bit_en u_ref (
    .clk      (clk),
    .en       (beat_hit),
    .load     (accept && !in_lock && lfsr_in.last),
    .load_val (lfsr_in.data),
    .state    (ref_state),
    .state_nxt(ref_nxt)
  );

  // rdy is computed from the next counter value so it lines up with the count
  // it reflects, and never looks at vld.
  assign bp_cnt_nxt = (bp_cnt == BP_TOP) ? 8'd0 : bp_cnt + 8'd1;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      bp_cnt      <= 8'd0;
      lfsr_in.rdy <= 1'b0;
    end else begin
      bp_cnt      <= bp_cnt_nxt;
      lfsr_in.rdy <= (BP_EN != 0) ? (bp_cnt_nxt != BP_TOP) : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state    <= HUNT;
      beat_cnt <= '0;
      run_cnt  <= '0;
    end else if (accept) begin
      if (!in_lock) begin
        if (lfsr_in.last) begin
          state    <= LOCK;
          beat_cnt <= '0;
          run_cnt  <= '0;
        end
      end else begin
        beat_cnt <= at_end ? '0 : beat_cnt + BCW'(1);
        if (!data_bad) begin
          run_cnt <= '0;
        end else if (lost) begin
          state   <= HUNT;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_inc;
        end
      end
    end
  end

  // clr takes priority over any event on the same beat.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      frame_cnt    <= '0;
      data_err_cnt <= '0;
      last_err_cnt <= '0;
      err_sticky   <= 1'b0;
    end else if (clr) begin
      frame_cnt    <= '0;
      data_err_cnt <= '0;
      last_err_cnt <= '0;
      err_sticky   <= 1'b0;
    end else if (beat_hit) begin
      if (data_bad && (data_err_cnt != 16'hFFFF)) data_err_cnt <= data_err_cnt + 16'd1;
      if (last_bad && (last_err_cnt != 16'hFFFF)) last_err_cnt <= last_err_cnt + 16'd1;
      if (at_end) frame_cnt <= frame_cnt + 32'd1;
      if (data_bad || last_bad) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_chk.sv
// Directed bench for axis_chk: a per-beat scoreboard for the unthrottled
// instance, plus a second instance running with internal backpressure.
module tb_axis_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2, clr, clr2;
  logic        locked, locked2, sticky, sticky2;
  logic [31:0] frames, frames2;
  logic [15:0] derr, derr2, lerr, lerr2;

  axis_if #(.DATAW(64)) if1 ();
  axis_if #(.DATAW(64)) if2 ();

  axis_chk #(.N(16), .DATAW(64), .BP_EN(0), .BP_PERIOD(7), .LOSS_THR(4)) dut1 (
    .clk(clk), .a_rst(rst), .lfsr_in(if1), .clr(clr), .locked(locked),
    .frame_cnt(frames), .data_err_cnt(derr), .last_err_cnt(lerr), .err_sticky(sticky)
  );

  axis_chk #(.N(16), .DATAW(64), .BP_EN(1), .BP_PERIOD(7), .LOSS_THR(4)) dut2 (
    .clk(clk), .a_rst(rst2), .lfsr_in(if2), .clr(clr2), .locked(locked2),
    .frame_cnt(frames2), .data_err_cnt(derr2), .last_err_cnt(lerr2), .err_sticky(sticky2)
  );

  typedef struct {
    logic        lk;
    logic [15:0] de;
    logic [15:0] le;
    logic [31:0] fr;
    logic        st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // behavioural expectation for dut1
  bit          m_lk, m_st;
  int          m_beat, m_run, m_de, m_le;
  logic [31:0] m_fr;

  logic [63:0] cur1, cur2;
  int          idx1, idx2;

  function automatic logic [63:0] ref_next(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_lk = 0; m_st = 0; m_beat = 0; m_run = 0; m_de = 0; m_le = 0; m_fr = 0;
  endtask

  task automatic model_step(input bit bad, input bit l);
    if (!m_lk) begin
      if (l) begin m_lk = 1; m_beat = 0; m_run = 0; end
    end else begin
      if (bad) begin
        if (m_de < 65535) m_de++;
        m_run++;
        m_st = 1;
      end else begin
        m_run = 0;
      end
      if (l != (m_beat == 15)) begin m_le++; m_st = 1; end
      if (m_beat == 15) begin m_fr++; m_beat = 0; end else m_beat++;
      if (m_run == 4) begin m_lk = 0; m_run = 0; end
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  // lmode: 0 = natural framing, 1 = force last low, 2 = force last high.
  task automatic beat1(input logic [63:0] mask, input int lmode, input logic do_clr);
    logic l;
    int   guard;
    l = ((idx1 % 16) == 5);
    if (lmode == 1) l = 1'b0;
    if (lmode == 2) l = 1'b1;
    if1.data = cur1 ^ mask;
    if1.last = l;
    if1.vld  = 1'b1;
    clr      = do_clr;
    guard    = 0;
    while (!if1.rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      $display("FAIL rdy_wait: got rdy=%0b, want 1 within 20 cycles", if1.rdy);
      $fatal(1, "rdy never rose");
    end
    @(posedge clk);
    model_step(mask != 64'd0, l);
    if (do_clr) begin m_de = 0; m_le = 0; m_fr = 0; m_st = 0; end
    sb.push_back('{m_lk, 16'(m_de), 16'(m_le), m_fr, m_st});
    cur1 = ref_next(cur1);
    idx1++;
    @(negedge clk);
    if1.vld = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic pulse_clr();
    clr     = 1'b1;
    if1.vld = 1'b0;
    @(posedge clk);
    m_de = 0; m_le = 0; m_fr = 0; m_st = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic finish_frame();
    while ((idx1 % 16) != 6) beat1(64'd0, 0, 1'b0);
  endtask

  // Scoreboard monitor: one expectation per accepted beat, checked after the edge.
  always @(posedge clk) begin
    if (!rst && if1.vld && if1.rdy) begin
      @(negedge clk);
      chk("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("locked", locked, mon_e.lk);
        chk("data_err_cnt", derr, mon_e.de);
        chk("last_err_cnt", lerr, mon_e.le);
        chk("frame_cnt", frames, mon_e.fr);
        chk("err_sticky", sticky, mon_e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, lows, last_low, cyc;
    logic r;
    rst = 1'b1; rst2 = 1'b1; clr = 1'b0; clr2 = 1'b0;
    if1.vld = 1'b0; if1.last = 1'b0; if1.data = '0;
    if2.vld = 1'b0; if2.last = 1'b0; if2.data = '0;
    model_reset();
    cur1 = 64'h0123_4567_89AB_CDEF; idx1 = 0;
    #2;
    chk("rst_rdy", if1.rdy, 1'b0);
    chk("rst_rdy2", if2.rdy, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_frames", frames, 32'd0);
    chk("rst_derr", derr, 16'd0);
    chk("rst_lerr", lerr, 16'd0);
    chk("rst_sticky", sticky, 1'b0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    chk("rdy_before_edge", if1.rdy, 1'b0);

    // 1: lock on the first last (beat 5), then 10 clean frames
    repeat (6 + 160) beat1(64'd0, 0, 1'b0);
    chk("t1_frames", frames, 32'd10);
    chk("t1_derr", derr, 16'd0);
    chk("t1_lerr", lerr, 16'd0);
    chk("t1_locked", locked, 1'b1);

    // 2: single bit-0 corruption
    repeat (3) beat1(64'd0, 0, 1'b0);
    beat1(64'd1, 0, 1'b0);
    beat1(64'd0, 0, 1'b0);
    chk("t2_derr", derr, 16'd1);
    chk("t2_sticky", sticky, 1'b1);
    chk("t2_locked", locked, 1'b1);
    finish_frame();

    // 3: four consecutive bad beats lose lock; relock on the next last
    pulse_clr();
    chk("t3_clr_derr", derr, 16'd0);
    chk("t3_clr_sticky", sticky, 1'b0);
    repeat (2) beat1(64'd0, 0, 1'b0);
    repeat (3) beat1(64'h8000_0000_0000_0000, 0, 1'b0);
    chk("t3_still_locked", locked, 1'b1);
    beat1(64'h8000_0000_0000_0000, 0, 1'b0);
    chk("t3_derr", derr, 16'd4);
    chk("t3_unlocked", locked, 1'b0);
    finish_frame();
    chk("t3_relocked", locked, 1'b1);

    // 4: last early on beat 14 and missing on beat 15
    pulse_clr();
    for (int k = 0; k < 16; k++) beat1(64'd0, (k == 14) ? 2 : ((k == 15) ? 1 : 0), 1'b0);
    chk("t4_lerr", lerr, 16'd2);
    chk("t4_frames", frames, 32'd1);
    chk("t4_derr", derr, 16'd0);
    repeat (16) beat1(64'd0, 0, 1'b0);
    chk("t4_frames2", frames, 32'd2);

    // 6: clr coinciding with an error, then reset mid-frame
    beat1(64'h10, 0, 1'b1);
    chk("t6_clr_wins_derr", derr, 16'd0);
    chk("t6_clr_wins_sticky", sticky, 1'b0);
    repeat (2) beat1(64'd0, 0, 1'b0);
    beat1(64'h4, 0, 1'b0);
    chk("t6_pre_rst_derr", derr, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_derr", derr, 16'd0);
    chk("t6_rst_frames", frames, 32'd0);
    chk("t6_rst_locked", locked, 1'b0);
    chk("t6_rst_sticky", sticky, 1'b0);
    chk("t6_rst_rdy", if1.rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("t6_rdy_held_low", if1.rdy, 1'b0);
    @(posedge clk);
    #1 chk("t6_rdy_rises", if1.rdy, 1'b1);
    @(negedge clk);
    finish_frame();
    chk("t6_relocked", locked, 1'b1);
    repeat (16) beat1(64'd0, 0, 1'b0);
    chk("t6_frames", frames, 32'd1);
    chk("t6_derr", derr, 16'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // 5: internal backpressure with vld held high, data held while stalled
    cur2 = 64'hFEDC_BA98_7654_3210; idx2 = 0;
    acc = 0; lows = 0; last_low = -1; cyc = 0;
    if2.vld = 1'b1;
    while (acc < 100 && cyc < 400) begin
      if2.data = cur2;
      if2.last = ((idx2 % 16) == 15);
      r = if2.rdy;
      if (!r) begin
        lows++;
        if (last_low >= 0) chk("bp_spacing", 64'(cyc - last_low), 64'd7);
        last_low = cyc;
      end
      @(posedge clk);
      if (r) begin
        cur2 = ref_next(cur2);
        idx2++;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    if2.vld = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd100);
    chk("bp_low_count", ((lows == cyc / 7) || (lows == cyc / 7 + 1)), 1'b1);
    chk("bp_locked", locked2, 1'b1);
    chk("bp_derr", derr2, 16'd0);
    chk("bp_lerr", lerr2, 16'd0);
    chk("bp_frames", frames2, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
